// File: rtl/seq_mult_ctrl_if.sv
// Job-request and datapath-control bundle between the job issuer,
// the digit-serial multiplier sequencer and its seq_mult datapath.
interface seq_mult_ctrl_if #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
);
  localparam int D   = MAX_WIDTH / P;
  localparam int BSW = $clog2(D) + 1;
  localparam int SW  = $clog2(D);

  logic                   req_valid;
  logic                   req_ready;
  logic [BSW-1:0]         req_bitsize;
  logic                   req_signed;
  logic [MAX_WIDTH-1:0]   req_a;
  logic [MAX_WIDTH-1:0]   req_b;
  logic [4*P-1:0]         req_init;

  logic [MAX_WIDTH-1:0]   mul_a;
  logic [MAX_WIDTH-1:0]   mul_b;
  logic [4*P-1:0]         mul_init_sum;
  logic                   mul_start;
  logic                   mul_count_last2;
  logic                   mul_last_out;
  logic                   mul_count_down;
  logic                   mul_invert_first_bit;
  logic                   mul_invert_second_row;
  logic                   mul_place_one;
  logic [SW-1:0]          mul_sel_a;
  logic [SW-1:0]          mul_sel_b;
  logic [1:0]             mul_count_shift_input;
  logic [BSW-1:0]         mul_bitsize;

  logic                   dig_valid;
  logic [3:0]             dig_idx;
  logic                   done;
  logic                   err;

  modport master (
    output req_valid, req_bitsize, req_signed, req_a, req_b, req_init,
    input  req_ready, mul_a, mul_b, mul_init_sum, mul_start, mul_count_last2,
           mul_last_out, mul_count_down, mul_invert_first_bit,
           mul_invert_second_row, mul_place_one, mul_sel_a, mul_sel_b,
           mul_count_shift_input, mul_bitsize, dig_valid, dig_idx, done, err
  );

  modport slave (
    input  req_valid, req_bitsize, req_signed, req_a, req_b, req_init,
    output req_ready, mul_a, mul_b, mul_init_sum, mul_start, mul_count_last2,
           mul_last_out, mul_count_down, mul_invert_first_bit,
           mul_invert_second_row, mul_place_one, mul_sel_a, mul_sel_b,
           mul_count_shift_input, mul_bitsize, dig_valid, dig_idx, done, err
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the digit-serial multiplier: accepts a job, walks the
// product columns one digit pair per cycle and flags each product digit.
//
// state | meaning
// IDLE  | ready for a job; illegal bitsize answered with an err pulse
// LOAD  | operands latched, datapath start strobe
// MAC   | one digit pair (i,j) per cycle, column by column
// DRAIN | final carry digit pushed out of the datapath
// DONE  | job-complete pulse, last digit valid
module seq_mult_ctrl #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  seq_mult_ctrl_if.slave bus
);
  localparam int D   = MAX_WIDTH / P;
  localparam int BSW = $clog2(D) + 1;
  localparam int SW  = $clog2(D);
  localparam logic [BSW-1:0] ONE  = BSW'(1);
  localparam logic [BSW-1:0] DMAX = BSW'(D);
  localparam logic [BSW:0]   TWO  = (BSW+1)'(2);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [SW-1:0] sel_a;
    logic [SW-1:0] sel_b;
    logic          last2;
    logic          down;
    logic          inv_first;
    logic          inv_second;
    logic          place_one;
  } pair_ctl_t;

  state_t               state_q;
  logic                 ready_q;
  logic [MAX_WIDTH-1:0] a_q, b_q;
  logic [4*P-1:0]       init_q;
  logic [BSW-1:0]       n_q;
  logic                 sgn_q;
  logic [BSW-1:0]       k_q, i_q;
  pair_ctl_t            ctl_q;
  logic                 start_q, last_out_q, done_q, err_q;
  logic                 dig_valid_q;
  logic [3:0]           dig_idx_q;

  logic                 legal;
  logic                 last_in_col, last_pair;
  logic [BSW-1:0]       k_d, i_d;

  // Lowest row index that contributes to column k.
  function automatic logic [BSW-1:0] col_imin(input logic [BSW-1:0] k,
                                              input logic [BSW-1:0] n);
    return (k >= n) ? (k - n + ONE) : '0;
  endfunction

  // Highest row index that contributes to column k.
  function automatic logic [BSW-1:0] col_imax(input logic [BSW-1:0] k,
                                              input logic [BSW-1:0] n);
    return (k < n) ? k : (n - ONE);
  endfunction

  // Datapath strobes for digit pair (i, k-i); sign strobes only on signed jobs.
  function automatic pair_ctl_t pair_ctl(input logic [BSW-1:0] k,
                                         input logic [BSW-1:0] i,
                                         input logic [BSW-1:0] n,
                                         input logic           sgn);
    pair_ctl_t      c;
    logic [BSW-1:0] j;
    j            = k - i;
    c.sel_a      = i[SW-1:0];
    c.sel_b      = j[SW-1:0];
    c.last2      = (i == col_imax(k, n));
    c.down       = (k >= n);
    c.inv_first  = sgn & (i == n - ONE) & (j != n - ONE);
    c.inv_second = sgn & (j == n - ONE) & (i != n - ONE);
    c.place_one  = sgn & ((n == ONE) | ((k == n) & (i == col_imin(k, n))));
    return c;
  endfunction

  // Successor of the current digit pair and end-of-schedule detection.
  always_comb begin
    legal       = (bus.req_bitsize != '0) && (bus.req_bitsize <= DMAX);
    last_in_col = (i_q == col_imax(k_q, n_q));
    last_pair   = last_in_col && ({1'b0, k_q} == ({n_q, 1'b0} - TWO));
    k_d         = last_in_col ? (k_q + ONE) : k_q;
    i_d         = last_in_col ? col_imin(k_d, n_q) : (i_q + ONE);
  end

  // Job FSM with registered datapath strobes and digit reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      init_q      <= '0;
      n_q         <= '0;
      sgn_q       <= 1'b0;
      k_q         <= '0;
      i_q         <= '0;
      ctl_q       <= '0;
      start_q     <= 1'b0;
      last_out_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_idx_q   <= '0;
    end else begin
      start_q     <= 1'b0;
      last_out_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ctl_q       <= '0;
      dig_valid_q <= ctl_q.last2 | last_out_q;
      if (dig_valid_q) dig_idx_q <= dig_idx_q + 4'd1;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            init_q <= bus.req_init;
            n_q    <= bus.req_bitsize;
            sgn_q  <= bus.req_signed;
            if (legal) begin
              state_q <= LOAD;
              start_q <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          state_q <= MAC;
          k_q     <= '0;
          i_q     <= '0;
          ctl_q   <= pair_ctl('0, '0, n_q, sgn_q);
        end
        MAC: begin
          if (last_pair) begin
            state_q    <= DRAIN;
            last_out_q <= 1'b1;
          end else begin
            k_q   <= k_d;
            i_q   <= i_d;
            ctl_q <= pair_ctl(k_d, i_d, n_q, sgn_q);
          end
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q   <= IDLE;
          ready_q   <= 1'b1;
          dig_idx_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready             = ready_q;
  assign bus.mul_a                 = a_q;
  assign bus.mul_b                 = b_q;
  assign bus.mul_init_sum          = init_q;
  assign bus.mul_bitsize           = n_q;
  assign bus.mul_start             = start_q;
  assign bus.mul_count_last2       = ctl_q.last2;
  assign bus.mul_last_out          = last_out_q;
  assign bus.mul_count_down        = ctl_q.down;
  assign bus.mul_invert_first_bit  = ctl_q.inv_first;
  assign bus.mul_invert_second_row = ctl_q.inv_second;
  assign bus.mul_place_one         = ctl_q.place_one;
  assign bus.mul_sel_a             = ctl_q.sel_a;
  assign bus.mul_sel_b             = ctl_q.sel_b;
  assign bus.mul_count_shift_input = 2'b00;
  assign bus.dig_valid             = dig_valid_q;
  assign bus.dig_idx               = dig_idx_q;
  assign bus.done                  = done_q;
  assign bus.err                   = err_q;
endmodule
